bcd_event_counter: RTL and testbench

Parametrised successor to the single-button decimal counter. Debounces two asynchronous push-button inputs (up, down) and turns each clean press into a one-cycle event. Each event steps a DIGITS-wide packed-BCD counter and its binary mirror, with selectable wrap or saturate behaviour at the range limits. Sits between the board buttons and the 4-digit seven-segment display driver and LED bank, replacing the slow-clock-triggered counter with a fully synchronous single-clock design.

---
 rtl/bcd_event_counter.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_event_counter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_event_counter.sv
// bcd_event_counter
// Debounces raw up/down push buttons into single-cycle press events and steps
// a packed-BCD counter plus its binary mirror. Limits either wrap or saturate.
// Everything runs on one clock; reset is asynchronous and active-low.

module bcd_event_counter #(
  parameter int DIGITS          = 4,
  parameter int BIN_W           = 16,
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter bit WRAP            = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [BIN_W-1:0]    count_bin,
  output logic                step_pulse,
  output logic                overflow,
  output logic                underflow
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DCNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  // Number of distinct counter values, 10^DIGITS.
  localparam longint unsigned RANGE = longint'(10) ** DIGITS;
  localparam logic [BIN_W-1:0]    MAX_BIN = BIN_W'(RANGE - 1);
  localparam logic [4*DIGITS-1:0] MAX_BCD = {DIGITS{4'h9}};

  // Reject parameter sets the counter cannot represent.
  if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
    $error("bcd_event_counter: DIGITS must lie in 1..6");
  end
  if ((64'd1 << BIN_W) < RANGE) begin : g_bad_bin_w
    $error("bcd_event_counter: BIN_W too narrow for 10^DIGITS values");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("bcd_event_counter: DEBOUNCE_CYCLES must be at least 2");
  end

  // Button channel index: bit 0 is the up button, bit 1 the down button.
  logic [1:0] btn_raw;
  assign btn_raw = {btn_down, btn_up};

  // Synchroniser, accepted level and registered rising-edge event per button.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] db_q, db_d;
  logic [1:0] rise_q, rise_d;
  logic [DCNT_W-1:0] dcnt_q [2];
  logic [DCNT_W-1:0] dcnt_d [2];

  // Counter state and registered pulse outputs.
  logic [4*DIGITS-1:0] count_bcd_q, count_bcd_d;
  logic [BIN_W-1:0]    count_bin_q, count_bin_d;
  logic                step_pulse_q, step_pulse_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  // BCD neighbours of the current value and limit flags.
  logic [4*DIGITS-1:0] bcd_inc, bcd_dec;
  logic                up_evt, down_evt;
  logic                at_max, at_zero;

  // Two-flop synchroniser feeding each debouncer.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // a rising accepted level becomes a one-cycle event on the following cycle.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == db_q[b]) begin
        dcnt_d[b] = '0;
      end else if (dcnt_q[b] == DCNT_LAST) begin
        db_d[b]   = sync2_q[b];
        dcnt_d[b] = '0;
      end else begin
        dcnt_d[b] = dcnt_q[b] + DCNT_W'(1);
      end
    end
    rise_d = db_d & ~db_q;
  end

  assign up_evt   = rise_q[0];
  assign down_evt = rise_q[1];
  assign at_max   = (count_bin_q == MAX_BIN);
  assign at_zero  = (count_bin_q == '0);

  // BCD increment: digits at 9 roll to 0 and carry into the next digit.
  always_comb begin
    logic carry;
    carry   = 1'b1;
    bcd_inc = count_bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = count_bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // BCD decrement: digits at 0 roll to 9 and borrow from the next digit.
  always_comb begin
    logic borrow;
    borrow  = 1'b1;
    bcd_dec = count_bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = count_bcd_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Next count and pulses: clear beats everything, opposing events cancel,
  // then a lone up or down event steps, wraps or saturates.
  always_comb begin
    count_bcd_d  = count_bcd_q;
    count_bin_d  = count_bin_q;
    step_pulse_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    if (clear) begin
      count_bcd_d = '0;
      count_bin_d = '0;
    end else if (up_evt && !down_evt) begin
      if (at_max) begin
        overflow_d = 1'b1;
        if (WRAP) begin
          count_bcd_d  = '0;
          count_bin_d  = '0;
          step_pulse_d = 1'b1;
        end
      end else begin
        count_bcd_d  = bcd_inc;
        count_bin_d  = count_bin_q + BIN_W'(1);
        step_pulse_d = 1'b1;
      end
    end else if (down_evt && !up_evt) begin
      if (at_zero) begin
        underflow_d = 1'b1;
        if (WRAP) begin
          count_bcd_d  = MAX_BCD;
          count_bin_d  = MAX_BIN;
          step_pulse_d = 1'b1;
        end
      end else begin
        count_bcd_d  = bcd_dec;
        count_bin_d  = count_bin_q - BIN_W'(1);
        step_pulse_d = 1'b1;
      end
    end
  end

  // All state registers; reset clears every stage without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      rise_q       <= '0;
      dcnt_q[0]    <= '0;
      dcnt_q[1]    <= '0;
      count_bcd_q  <= '0;
      count_bin_q  <= '0;
      step_pulse_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      rise_q       <= rise_d;
      dcnt_q[0]    <= dcnt_d[0];
      dcnt_q[1]    <= dcnt_d[1];
      count_bcd_q  <= count_bcd_d;
      count_bin_q  <= count_bin_d;
      step_pulse_q <= step_pulse_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign count_bcd  = count_bcd_q;
  assign count_bin  = count_bin_q;
  assign step_pulse = step_pulse_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// tb_bcd_event_counter
// Drives a wrapping 4-digit counter and a saturating 2-digit counter from the
// same buttons and compares both against a value-level reference model.

module tb_bcd_event_counter;

  localparam int D       = 4;
  localparam int RANGE_W = 10000;
  localparam int RANGE_S = 100;

  logic clk;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic clear;

  logic [15:0] bcdW;
  logic [15:0] binW;
  logic        stepW, ovfW, unfW;
  logic [7:0]  bcdS;
  logic [6:0]  binS;
  logic        stepS, ovfS, unfS;

  int vectorCount = 0;
  int miscompareCount = 0;

  bcd_event_counter #(
    .DIGITS(4), .BIN_W(16), .DEBOUNCE_CYCLES(D), .WRAP(1'b1)
  ) dutWrap (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .count_bcd(bcdW), .count_bin(binW),
    .step_pulse(stepW), .overflow(ovfW), .underflow(unfW)
  );

  bcd_event_counter #(
    .DIGITS(2), .BIN_W(7), .DEBOUNCE_CYCLES(D), .WRAP(1'b0)
  ) dutSat (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .count_bcd(bcdS), .count_bin(binS),
    .step_pulse(stepS), .overflow(ovfS), .underflow(unfS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the model and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Decimal value to packed BCD, digit by digit.
  function automatic logic [31:0] toBcd(input int v, input int digits);
    logic [31:0] r;
    int rest;
    r = '0;
    rest = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return r;
  endfunction

  // Counter behaviour as plain modular/clamped arithmetic on an integer.
  function automatic void stepModel(input int v, input int m, input bit wrap,
                                    input bit up, input bit dn, input bit clr,
                                    output int nv, output bit st,
                                    output bit ov, output bit un);
    nv = v; st = 1'b0; ov = 1'b0; un = 1'b0;
    if (clr) begin
      nv = 0;
    end else if (up && !dn) begin
      if (v == m - 1) begin
        ov = 1'b1;
        nv = wrap ? 0 : v;
      end else begin
        nv = v + 1;
      end
      st = (nv != v);
    end else if (dn && !up) begin
      if (v == 0) begin
        un = 1'b1;
        nv = wrap ? m - 1 : 0;
      end else begin
        nv = v - 1;
      end
      st = (nv != v);
    end
  endfunction

  // A level is accepted once the D samples taken two edges or more ago all
  // disagree with the accepted level; returns {new level, rose}.
  function automatic logic [1:0] debounceModel(input logic [D+1:0] hist, input bit db);
    logic [D-1:0] window;
    window = hist[D+1:2];
    if (!db && (&window)) return 2'b11;
    if (db && !(|window)) return 2'b00;
    return {db, 1'b0};
  endfunction

  logic [D+1:0] histUp = '0;
  logic [D+1:0] histDn = '0;
  bit dbUp = 0, dbDn = 0, pendUp = 0, pendDn = 0;
  int valW = 0, valS = 0;
  bit expStepW = 0, expOvfW = 0, expUnfW = 0;
  bit expStepS = 0, expOvfS = 0, expUnfS = 0;

  // Reference model: events accepted on one edge move the count on the next.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      histUp = '0; histDn = '0;
      dbUp = 0; dbDn = 0; pendUp = 0; pendDn = 0;
      valW = 0; valS = 0;
      expStepW = 0; expOvfW = 0; expUnfW = 0;
      expStepS = 0; expOvfS = 0; expUnfS = 0;
    end else begin
      stepModel(valW, RANGE_W, 1'b1, pendUp, pendDn, clear, valW, expStepW, expOvfW, expUnfW);
      stepModel(valS, RANGE_S, 1'b0, pendUp, pendDn, clear, valS, expStepS, expOvfS, expUnfS);
      histUp = {histUp[D:0], btn_up};
      histDn = {histDn[D:0], btn_down};
      {dbUp, pendUp} = debounceModel(histUp, dbUp);
      {dbDn, pendDn} = debounceModel(histDn, dbDn);
    end
  end

  // Every cycle, both counters must match the model on all outputs.
  always @(negedge clk) begin
    checkOutput("bcdW", 32'(bcdW), toBcd(valW, 4));
    checkOutput("binW", 32'(binW), 32'(valW));
    checkOutput("stepW", 32'(stepW), 32'(expStepW));
    checkOutput("ovfW", 32'(ovfW), 32'(expOvfW));
    checkOutput("unfW", 32'(unfW), 32'(expUnfW));
    checkOutput("bcdS", 32'(bcdS), toBcd(valS, 2));
    checkOutput("binS", 32'(binS), 32'(valS));
    checkOutput("stepS", 32'(stepS), 32'(expStepS));
    checkOutput("ovfS", 32'(ovfS), 32'(expOvfS));
    checkOutput("unfS", 32'(unfS), 32'(expUnfS));
  end

  logic [15:0] snapBcdW, snapBinW;
  logic        snapStepW, snapOvfW, snapUnfW;
  logic [7:0]  snapBcdS;
  logic        snapStepS, snapOvfS, snapUnfS;

  // One clean press (optionally with clear landing on the maturing edge);
  // outputs are captured on the cycle the resulting event lands.
  task automatic applyStimulus(input bit up, input bit dn, input bit clrAtMature);
    @(negedge clk);
    btn_up = up;
    btn_down = dn;
    repeat (D + 2) @(negedge clk);
    if (clrAtMature) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    snapBcdW = bcdW; snapBinW = binW;
    snapStepW = stepW; snapOvfW = ovfW; snapUnfW = unfW;
    snapBcdS = bcdS;
    snapStepS = stepS; snapOvfS = ovfS; snapUnfS = unfS;
    @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (D + 4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; clear = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bcd", 32'(bcdW), 32'h0);
    checkOutput("rst_step", 32'(stepW), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Bouncing press: runs of 3 high samples never qualify, the final hold does.
    for (int p = 0; p < 10; p++) begin
      btn_up = 1'b1;
      repeat (3) @(negedge clk);
      btn_up = 1'b0;
      @(negedge clk);
    end
    btn_up = 1'b1;
    repeat (12) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("bounce_bcd", 32'(bcdW), 32'h0001);
    checkOutput("bounce_bin", 32'(binW), 32'd1);

    // Synchronous clear zeroes the count without a step pulse.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_bcd", 32'(bcdW), 32'h0);
    checkOutput("clr_step", 32'(stepW), 32'h0);

    // Preload to 1099, then exercise digit carry and borrow.
    repeat (1099) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_bcd", 32'(bcdW), 32'h1099);
    checkOutput("pre_bin", 32'(binW), 32'd1099);
    checkOutput("pre_bcdS", 32'(bcdS), 32'h99);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("carry_bcd", 32'(snapBcdW), 32'h1100);
    checkOutput("carry_bin", 32'(snapBinW), 32'd1100);
    checkOutput("carry_step", 32'(snapStepW), 32'h1);
    checkOutput("sat_ovf_bcd", 32'(snapBcdS), 32'h99);
    checkOutput("sat_ovf", 32'(snapOvfS), 32'h1);
    checkOutput("sat_ovf_step", 32'(snapStepS), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("borrow_bcd", 32'(snapBcdW), 32'h1099);
    checkOutput("borrow_unf", 32'(snapUnfW), 32'h0);
    checkOutput("sat_dec_bcd", 32'(snapBcdS), 32'h98);

    // Asynchronous reset in the middle of a debounce, button held through release.
    btn_up = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_bcd", 32'(bcdW), 32'h0);
    checkOutput("arst_bin", 32'(binW), 32'h0);
    checkOutput("arst_bcdS", 32'(bcdS), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (D + 2) @(negedge clk);
    checkOutput("lat_early", 32'(bcdW), 32'h0);
    @(negedge clk);
    checkOutput("lat_bcd", 32'(bcdW), 32'h0001);
    checkOutput("lat_step", 32'(stepW), 32'h1);
    @(negedge clk);
    checkOutput("lat_step_end", 32'(stepW), 32'h0);
    repeat (20) @(negedge clk);
    checkOutput("hold_once", 32'(bcdW), 32'h0001);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);

    // Wrap at zero and at max; saturate holds at zero.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dec_to0", 32'(snapBcdW), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("wrap_unf_bcd", 32'(snapBcdW), 32'h9999);
    checkOutput("wrap_unf_bin", 32'(snapBinW), 32'd9999);
    checkOutput("wrap_unf", 32'(snapUnfW), 32'h1);
    checkOutput("wrap_unf_step", 32'(snapStepW), 32'h1);
    checkOutput("sat_unf_bcd", 32'(snapBcdS), 32'h0);
    checkOutput("sat_unf", 32'(snapUnfS), 32'h1);
    checkOutput("sat_unf_step", 32'(snapStepS), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap_ovf_bcd", 32'(snapBcdW), 32'h0);
    checkOutput("wrap_ovf", 32'(snapOvfW), 32'h1);
    checkOutput("wrap_ovf_step", 32'(snapStepW), 32'h1);

    // Opposing events on one edge cancel.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_bcd", 32'(snapBcdW), 32'h0);
    checkOutput("both_step", 32'(snapStepW), 32'h0);
    checkOutput("both_ovf", 32'(snapOvfW), 32'h0);
    checkOutput("both_bcdS", 32'(snapBcdS), 32'h01);

    // Clear on the edge an up event matures wins, with no pulses.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clrev_bcd", 32'(snapBcdW), 32'h0);
    checkOutput("clrev_step", 32'(snapStepW), 32'h0);
    checkOutput("clrev_bcdS", 32'(snapBcdS), 32'h0);

    // Random button levels, hold times and occasional clears.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      btn_up = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      clear = 1'b0;
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
